// File: rtl/mpu_alu_sched_pkg.sv
// Shared types and constants for the MPU ALU scheduler.
package mpu_alu_sched_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned OPND_W = 64;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned NOPND  = 4;
   localparam int unsigned NSEL   = 5;

   localparam logic [OP_W-1:0] MPU_OP_NONE = 4'h0;
   localparam logic [OP_W-1:0] MPU_OP_MASK = 4'h1;
   localparam logic [OP_W-1:0] MPU_OP_CMP  = 4'h2;
   localparam logic [OP_W-1:0] MPU_OP_LT   = 4'h3;
   localparam logic [OP_W-1:0] MPU_OP_ADD  = 4'h4;
   localparam logic [OP_W-1:0] MPU_OP_HAMM = 4'h5;

   typedef enum logic [1:0] {
      MPU_SCHED_IDLE = 2'd0,
      MPU_SCHED_EXEC = 2'd1,
      MPU_SCHED_RESP = 2'd2
   } sched_state_e;

   // One ALU operation as latched from a requester.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [SIZE_W-1:0] size;
      logic [OPND_W-1:0] o0;
      logic [OPND_W-1:0] o1;
      logic [OPND_W-1:0] o2;
      logic [OPND_W-1:0] o3;
      logic [SEL_W-1:0]  s0;
      logic [SEL_W-1:0]  s1;
      logic [SEL_W-1:0]  s2;
      logic [SEL_W-1:0]  s3;
      logic [SEL_W-1:0]  sres;
   } alu_req_t;

   // True for op codes the ALU implements.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op == MPU_OP_NONE) || (op == MPU_OP_MASK) || (op == MPU_OP_CMP) ||
             (op == MPU_OP_LT)   || (op == MPU_OP_ADD)  || (op == MPU_OP_HAMM);
   endfunction

endpackage

// File: rtl/mpu_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod NREQ.
module mpu_rr_arb #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   localparam int unsigned SW = IW + 1;

   logic [SW-1:0] pos;

   // Walk positions ptr, ptr+1, ... and take the first one with a request.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      pos     = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         pos = SW'(ptr) + SW'(j);
         if (pos >= SW'(NREQ)) pos = pos - SW'(NREQ);
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (pos == SW'(i))) begin
               any     = 1'b1;
               gnt_idx = IW'(i);
            end
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         gnt[i] = any && (gnt_idx == IW'(i));
      end
   end

endmodule

// File: rtl/mpu_alu_sched.sv
// Round-robin scheduler sharing one external mpu_alu between NREQ requesters.
module mpu_alu_sched
   import mpu_alu_sched_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [OP_W*NREQ-1:0]      req_op,
   input  logic [SIZE_W*NREQ-1:0]    req_size,
   input  logic [OPND_W*NOPND*NREQ-1:0] req_o,
   input  logic [SEL_W*NSEL*NREQ-1:0] req_sel,
   output logic [NREQ-1:0]           req_ack,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [OPND_W-1:0]         rsp_res,
   output logic                      rsp_err,
   output logic                      busy,
   output logic [OP_W-1:0]           alu_op,
   output logic [SIZE_W-1:0]         alu_size,
   output logic [OPND_W-1:0]         alu_o0,
   output logic [OPND_W-1:0]         alu_o1,
   output logic [OPND_W-1:0]         alu_o2,
   output logic [OPND_W-1:0]         alu_o3,
   output logic [SEL_W-1:0]          alu_s0,
   output logic [SEL_W-1:0]          alu_s1,
   output logic [SEL_W-1:0]          alu_s2,
   output logic [SEL_W-1:0]          alu_s3,
   output logic [SEL_W-1:0]          alu_sres,
   input  logic [OPND_W-1:0]         alu_res
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Selector addresses a field beyond the 64b operand for this field size.
   function automatic logic sel_bad(input logic [SEL_W-1:0] sel, input logic [SIZE_W-1:0] size);
      return (sel >> (2'd3 - size)) != 3'd0;
   endfunction

   sched_state_e    state_q;
   logic [IW-1:0]   rr_q;
   logic [IW-1:0]   g_q;
   logic [NREQ-1:0] g_oh_q;
   logic            err_q;
   alu_req_t        alu_q;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   alu_req_t        cand;
   logic            cand_err;
   logic [IW-1:0]   rr_next;
   logic            rsp_take;

   mpu_rr_arb #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   // Select the granted requester's payload and judge its legality.
   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            cand.op   = req_op  [OP_W*i   +: OP_W];
            cand.size = req_size[SIZE_W*i +: SIZE_W];
            cand.o0   = req_o[OPND_W*(NOPND*i + 0) +: OPND_W];
            cand.o1   = req_o[OPND_W*(NOPND*i + 1) +: OPND_W];
            cand.o2   = req_o[OPND_W*(NOPND*i + 2) +: OPND_W];
            cand.o3   = req_o[OPND_W*(NOPND*i + 3) +: OPND_W];
            cand.s0   = req_sel[SEL_W*(NSEL*i + 0) +: SEL_W];
            cand.s1   = req_sel[SEL_W*(NSEL*i + 1) +: SEL_W];
            cand.s2   = req_sel[SEL_W*(NSEL*i + 2) +: SEL_W];
            cand.s3   = req_sel[SEL_W*(NSEL*i + 3) +: SEL_W];
            cand.sres = req_sel[SEL_W*(NSEL*i + 4) +: SEL_W];
         end
      end
      cand_err = !op_legal(cand.op) ||
                 sel_bad(cand.s0, cand.size) || sel_bad(cand.s1, cand.size) ||
                 sel_bad(cand.s2, cand.size) || sel_bad(cand.s3, cand.size) ||
                 sel_bad(cand.sres, cand.size);
   end

   // Pointer advance past the served requester and response handshake detect.
   always_comb begin
      rr_next  = (g_q == IW'(NREQ - 1)) ? '0 : g_q + IW'(1);
      rsp_take = |(rsp_ready & g_oh_q);
   end

   // Scheduler FSM: issue in IDLE, capture ALU result in EXEC, hold response in RESP.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= MPU_SCHED_IDLE;
         rr_q      <= '0;
         g_q       <= '0;
         g_oh_q    <= '0;
         err_q     <= 1'b0;
         alu_q     <= '0;
         req_ack   <= '0;
         rsp_valid <= '0;
         rsp_res   <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         req_ack <= '0;
         case (state_q)
            MPU_SCHED_IDLE: begin
               if (gnt_any) begin
                  alu_q   <= cand;
                  err_q   <= cand_err;
                  g_q     <= gnt_idx;
                  g_oh_q  <= gnt;
                  req_ack <= gnt;
                  busy    <= 1'b1;
                  state_q <= MPU_SCHED_EXEC;
               end
            end
            MPU_SCHED_EXEC: begin
               rsp_res   <= alu_res;
               rsp_err   <= err_q;
               rsp_valid <= g_oh_q;
               state_q   <= MPU_SCHED_RESP;
            end
            MPU_SCHED_RESP: begin
               if (rsp_take) begin
                  rsp_valid <= '0;
                  rr_q      <= rr_next;
                  busy      <= 1'b0;
                  state_q   <= MPU_SCHED_IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_q <= MPU_SCHED_IDLE;
            end
         endcase
      end
   end

   assign alu_op   = alu_q.op;
   assign alu_size = alu_q.size;
   assign alu_o0   = alu_q.o0;
   assign alu_o1   = alu_q.o1;
   assign alu_o2   = alu_q.o2;
   assign alu_o3   = alu_q.o3;
   assign alu_s0   = alu_q.s0;
   assign alu_s1   = alu_q.s1;
   assign alu_s2   = alu_q.s2;
   assign alu_s3   = alu_q.s3;
   assign alu_sres = alu_q.sres;

endmodule

// File: tb/tb_mpu_alu_sched.sv
// Self-checking bench for mpu_alu_sched with a behavioural ALU stub and a transaction-level model.
module tb_mpu_alu_sched;
   import mpu_alu_sched_pkg::*;

   localparam int NREQ = 2;
   localparam int MODE_RANDOM  = 0;
   localparam int MODE_CONTEND = 1;
   localparam int MODE_BACKP   = 2;

   logic                  sys_clk = 1'b0;
   logic                  sys_rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [4*NREQ-1:0]     req_op;
   logic [2*NREQ-1:0]     req_size;
   logic [256*NREQ-1:0]   req_o;
   logic [15*NREQ-1:0]    req_sel;
   logic [NREQ-1:0]       req_ack;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [63:0]           rsp_res;
   logic                  rsp_err;
   logic                  busy;
   logic [3:0]            alu_op;
   logic [1:0]            alu_size;
   logic [63:0]           alu_o0, alu_o1, alu_o2, alu_o3;
   logic [2:0]            alu_s0, alu_s1, alu_s2, alu_s3, alu_sres;
   logic [63:0]           alu_res;

   logic [3:0]  b_op   [NREQ];
   logic [1:0]  b_size [NREQ];
   logic [63:0] b_o    [NREQ][4];
   logic [2:0]  b_sel  [NREQ][5];

   int n_total = 0;
   int n_bad   = 0;

   int              m_rr, m_stage, m_g;
   logic [NREQ-1:0] exp_ack, exp_rv;
   logic [63:0]     exp_res, p_res;
   logic            exp_err, p_err;
   int              gq[$];

   mpu_alu_sched #(.NREQ(NREQ)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_size  (req_size),
      .req_o     (req_o),
      .req_sel   (req_sel),
      .req_ack   (req_ack),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .alu_op    (alu_op),
      .alu_size  (alu_size),
      .alu_o0    (alu_o0),
      .alu_o1    (alu_o1),
      .alu_o2    (alu_o2),
      .alu_o3    (alu_o3),
      .alu_s0    (alu_s0),
      .alu_s1    (alu_s1),
      .alu_s2    (alu_s2),
      .alu_s3    (alu_s3),
      .alu_sres  (alu_sres),
      .alu_res   (alu_res)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural ALU: field = slice of (8<<size) bits picked by selector.
   function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [1:0] sz,
                                           input logic [63:0] o0, input logic [63:0] o1,
                                           input logic [63:0] o2, input logic [63:0] o3,
                                           input logic [2:0] s0, input logic [2:0] s1,
                                           input logic [2:0] s2, input logic [2:0] s3,
                                           input logic [2:0] sr);
      int unsigned w;
      logic [63:0] m, f0, f1, f2, f3;
      w  = 8 << sz;
      m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      f0 = (o0 >> (s0 * w)) & m;
      f1 = (o1 >> (s1 * w)) & m;
      f2 = (o2 >> (s2 * w)) & m;
      f3 = (o3 >> (s3 * w)) & m;
      case (op)
         4'h1:    return {63'd0, (f0 & f1) != 64'd0};
         4'h2:    return {63'd0, f0 == f1};
         4'h3:    return {63'd0, f0 < f1};
         4'h4:    return ((f1 + f2) & m) << (sr * w);
         4'h5:    return 64'($countones((f1 ^ f2) & f3));
         default: return 64'd0;
      endcase
   endfunction

   always_comb begin
      alu_res = alu_ref(alu_op, alu_size, alu_o0, alu_o1, alu_o2, alu_o3,
                        alu_s0, alu_s1, alu_s2, alu_s3, alu_sres);
   end

   // Flatten the per-requester payload arrays onto the DUT buses.
   always_comb begin
      req_op = '0; req_size = '0; req_o = '0; req_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_op[4*i +: 4]   = b_op[i];
         req_size[2*i +: 2] = b_size[i];
         for (int k = 0; k < 4; k++) req_o[256*i + 64*k +: 64] = b_o[i][k];
         for (int k = 0; k < 5; k++) req_sel[15*i + 3*k +: 3] = b_sel[i][k];
      end
   end

   function automatic logic [63:0] ref_of(input int i);
      return alu_ref(b_op[i], b_size[i], b_o[i][0], b_o[i][1], b_o[i][2], b_o[i][3],
                     b_sel[i][0], b_sel[i][1], b_sel[i][2], b_sel[i][3], b_sel[i][4]);
   endfunction

   // Malformed: unknown op, or a selector naming a field past the 64b operand.
   function automatic logic err_of(input int i);
      logic e;
      e = !(b_op[i] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
      for (int k = 0; k < 5; k++)
         if (int'(b_sel[i][k]) >= (8 >> b_size[i])) e = 1'b1;
      return e;
   endfunction

   task automatic rand_payload(input int i, input bit allow_bad);
      b_op[i]   = allow_bad && ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(0, 5));
      b_size[i] = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) b_o[i][k] = {$urandom, $urandom};
      for (int k = 0; k < 5; k++)
         b_sel[i][k] = allow_bad && ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                                               : 3'($urandom_range(0, (8 >> b_size[i]) - 1));
   endtask

   task automatic apply_reset();
      sys_rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         b_op[i] = '0; b_size[i] = '0;
         for (int k = 0; k < 4; k++) b_o[i][k] = '0;
         for (int k = 0; k < 5; k++) b_sel[i][k] = '0;
      end
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      m_rr = 0; m_stage = 0; m_g = 0;
      exp_ack = '0; exp_rv = '0; exp_res = '0; exp_err = 1'b0;
      gq.delete();
   endtask

   // One directed op on an idle scheduler with fixed ack/response latency.
   task automatic issue_one(input string name, input int r, input logic [3:0] op,
                            input logic [1:0] sz, input logic [63:0] o0, input logic [63:0] o1,
                            input logic [63:0] o2, input logic [63:0] o3, input logic [14:0] sels,
                            input logic [63:0] want_res, input logic want_err);
      logic [NREQ-1:0] oh;
      oh = '0; oh[r] = 1'b1;
      b_op[r] = op; b_size[r] = sz;
      b_o[r][0] = o0; b_o[r][1] = o1; b_o[r][2] = o2; b_o[r][3] = o3;
      for (int k = 0; k < 5; k++) b_sel[r][k] = sels[3*k +: 3];
      req_valid[r] = 1'b1;
      @(posedge sys_clk); #1;
      n_total++;
      if (req_ack !== oh || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_ack ack=%b busy=%b want ack=%b busy=1", name, req_ack, busy, oh);
      end
      n_total++;
      if (alu_op !== op) begin
         n_bad++; $display("FAIL %s_alu_op got=%h want=%h", name, alu_op, op);
      end
      req_valid[r] = 1'b0;
      @(posedge sys_clk); #1;
      n_total++;
      if (rsp_valid !== oh) begin
         n_bad++; $display("FAIL %s_rsp_valid got=%b want=%b", name, rsp_valid, oh);
      end
      n_total++;
      if (rsp_res !== want_res) begin
         n_bad++; $display("FAIL %s_res got=%h want=%h", name, rsp_res, want_res);
      end
      n_total++;
      if (rsp_err !== want_err) begin
         n_bad++; $display("FAIL %s_err got=%b want=%b", name, rsp_err, want_err);
      end
      rsp_ready = '1;
      @(posedge sys_clk); #1;
      rsp_ready = '0;
      n_total++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL %s_drain rsp_valid=%b busy=%b want 0/0", name, rsp_valid, busy);
      end
   endtask

   // Cycle-level traffic against the transaction model; each cycle checks ack and response.
   task automatic run_traffic(input int ncyc, input int mode);
      int wait_cnt = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge sys_clk); #1;
         n_total++;
         if (req_ack !== exp_ack) begin
            n_bad++; $display("FAIL traffic_ack mode=%0d cyc=%0d got=%b want=%b", mode, c, req_ack, exp_ack);
         end
         n_total++;
         if (rsp_valid !== exp_rv) begin
            n_bad++; $display("FAIL traffic_rsp_valid mode=%0d cyc=%0d got=%b want=%b", mode, c, rsp_valid, exp_rv);
         end
         if (exp_rv != '0) begin
            n_total++;
            if (rsp_res !== exp_res) begin
               n_bad++; $display("FAIL traffic_res mode=%0d cyc=%0d got=%h want=%h", mode, c, rsp_res, exp_res);
            end
            n_total++;
            if (rsp_err !== exp_err) begin
               n_bad++; $display("FAIL traffic_err mode=%0d cyc=%0d got=%b want=%b", mode, c, rsp_err, exp_err);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ack[i]) begin
               gq.push_back(i);
               if (mode == MODE_RANDOM && $urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
               else rand_payload(i, mode == MODE_RANDOM);
            end else if (!req_valid[i]) begin
               if (mode != MODE_RANDOM || $urandom_range(0, 2) == 0) begin
                  rand_payload(i, mode == MODE_RANDOM);
                  req_valid[i] = 1'b1;
               end
            end
         end
         if (mode == MODE_RANDOM) rsp_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         else if (mode == MODE_CONTEND) rsp_ready = '1;
         else if (m_stage == 2 && wait_cnt < 5) begin
            rsp_ready = '0; wait_cnt++;
         end else begin
            rsp_ready = '1;
            if (m_stage == 2) wait_cnt = 0;
         end
         exp_ack = '0;
         case (m_stage)
            0: begin
               exp_rv = '0;
               for (int k = 0; k < NREQ; k++) begin
                  int idx;
                  idx = (m_rr + k) % NREQ;
                  if (exp_ack == '0 && req_valid[idx]) begin
                     exp_ack[idx] = 1'b1; m_g = idx;
                  end
               end
               if (exp_ack != '0) begin
                  p_res = ref_of(m_g); p_err = err_of(m_g); m_stage = 1;
               end
            end
            1: begin
               exp_rv = '0; exp_rv[m_g] = 1'b1;
               exp_res = p_res; exp_err = p_err; m_stage = 2;
            end
            default: begin
               if (rsp_ready[m_g]) begin
                  exp_rv = '0; m_rr = (m_g + 1) % NREQ; m_stage = 0;
               end
            end
         endcase
      end
      req_valid = '0;
      rsp_ready = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++; if (req_ack !== '0) begin n_bad++; $display("FAIL reset_ack got=%b want=0", req_ack); end
      n_total++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      n_total++; if (rsp_res !== '0) begin n_bad++; $display("FAIL reset_res got=%h want=0", rsp_res); end
      n_total++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", rsp_err); end
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_total++;
      if ({alu_op, alu_size, alu_o0, alu_o1, alu_o2, alu_o3, alu_s0, alu_s1, alu_s2, alu_s3, alu_sres} !== '0) begin
         n_bad++; $display("FAIL reset_alu op=%h size=%h o1=%h want all 0", alu_op, alu_size, alu_o1);
      end
   endtask

   task automatic test_add();
      issue_one("add", 0, 4'h4, 2'd0, 64'd0, 64'h12, 64'h34, 64'd0, {3'd2, 3'd0, 3'd0, 3'd0, 3'd0},
                64'h46_0000, 1'b0);
   endtask

   task automatic test_errors();
      issue_one("err_qw_s0", 0, 4'h4, 2'd3, 64'd0, 64'd5, 64'd6, 64'd0, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1},
                64'd11, 1'b1);
      issue_one("err_w_sres", 1, 4'h4, 2'd1, 64'd0, 64'd1, 64'd2, 64'd0, {3'd4, 3'd0, 3'd0, 3'd0, 3'd0},
                64'd0, 1'b1);
      issue_one("err_op", 0, 4'hF, 2'd0, 64'hFF, 64'hFF, 64'hFF, 64'hFF, 15'd0, 64'd0, 1'b1);
      issue_one("ok_dw_s3", 1, 4'h5, 2'd2, 64'd0, 64'hFF, 64'd0, 64'h0000_000F_0000_0000,
                {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, 64'd4, 1'b0);
   endtask

   task automatic test_hamm_mask();
      issue_one("hamm", 0, 4'h5, 2'd0, 64'd0, 64'hFF, 64'h0F, 64'hFF, 15'd0, 64'd4, 1'b0);
      issue_one("mask", 1, 4'h1, 2'd0, 64'h3, 64'h1, 64'd0, 64'd0, 15'd0, 64'd1, 1'b0);
      issue_one("none", 0, 4'h0, 2'd0, 64'hAB, 64'hCD, 64'hEF, 64'h12, 15'd0, 64'd0, 1'b0);
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      issue_one("pre_rst", 0, 4'h4, 2'd0, 64'd0, 64'h12, 64'h34, 64'd0, 15'd0, 64'h46, 1'b0);
      b_op[1] = 4'h4; b_o[1][1] = 64'h7; b_o[1][2] = 64'h9;
      req_valid[1] = 1'b1;
      @(posedge sys_clk); #1;
      n_total++;
      if (req_ack !== 2'b10) begin n_bad++; $display("FAIL rst_mid_ack got=%b want=10", req_ack); end
      req_valid = '0;
      #1 sys_rst_n = 1'b0;
      #1;
      n_total++;
      if (req_ack !== '0 || rsp_valid !== '0 || busy !== 1'b0 || rsp_res !== '0 || rsp_err !== 1'b0 ||
          alu_op !== '0 || alu_o1 !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_clear ack=%b rv=%b busy=%b res=%h op=%h o1=%h want all 0",
                  req_ack, rsp_valid, busy, rsp_res, alu_op, alu_o1);
      end
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge sys_clk); #1;
         n_total++;
         if (req_ack !== '0 || rsp_valid !== '0) begin
            n_bad++; $display("FAIL rst_mid_quiet cyc=%0d ack=%b rv=%b want 0/0", c, req_ack, rsp_valid);
         end
      end
      req_valid = '1;
      @(posedge sys_clk); #1;
      n_total++;
      if (req_ack !== 2'b01) begin n_bad++; $display("FAIL rst_mid_regrant got=%b want=01", req_ack); end
      req_valid = '0;
      @(posedge sys_clk); #1;
      rsp_ready = '1;
      @(posedge sys_clk); #1;
      rsp_ready = '0;
   endtask

   task automatic test_contention();
      apply_reset();
      run_traffic(12, MODE_CONTEND);
      n_total++;
      if (gq.size() < 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 0 || gq[3] != 1) begin
         n_bad++; $display("FAIL contention_order grants=%p want 0,1,0,1", gq);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      run_traffic(24, MODE_BACKP);
      n_total++;
      if (gq.size() < 2 || gq[0] != 0 || gq[1] != 1) begin
         n_bad++; $display("FAIL backp_order grants=%p want 0,1,...", gq);
      end
   endtask

   task automatic test_random();
      apply_reset();
      run_traffic(600, MODE_RANDOM);
      n_total++;
      if (gq.size() < 20) begin
         n_bad++; $display("FAIL random_progress grants=%0d want>=20", gq.size());
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_errors();
      test_hamm_mask();
      test_reset_mid_op();
      test_contention();
      test_backpressure();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
